// File: rtl/ace_ccu_snoop_fanout.sv
// ace_ccu_snoop_fanout: broadcasts one ACE snoop (AC) to a masked set of ports, merges every CR, forwards CD from one responder.
// Optional ACE_CCU_SNOOP_FANOUT_CD_SPILL_EN: the upstream CD path goes through a 2-entry spill buffer.
package ace_ccu_snoop_fanout_pkg;
   typedef struct packed {
      logic [43:0] addr;
      logic [3:0]  snoop;
      logic [2:0]  prot;
   } snoop_ac_t;
   typedef logic [4:0] snoop_cr_t;
   typedef struct packed {
      logic [127:0] data;
      logic         last;
   } snoop_cd_t;
   typedef struct packed {
      snoop_ac_t ac;
      logic      ac_valid;
      logic      cr_ready;
      logic      cd_ready;
   } snoop_req_t;
   typedef struct packed {
      logic      ac_ready;
      logic      cr_valid;
      snoop_cr_t cr_resp;
      logic      cd_valid;
      snoop_cd_t cd;
   } snoop_resp_t;
endpackage

module ace_ccu_snoop_fanout #(
   parameter int unsigned NoMstPorts      = 4,
   parameter int unsigned DcacheLineWidth = 512,
   parameter int unsigned AxiDataWidth    = 128,
   parameter type snoop_ac_t    = ace_ccu_snoop_fanout_pkg::snoop_ac_t,
   parameter type snoop_cr_t    = ace_ccu_snoop_fanout_pkg::snoop_cr_t,
   parameter type snoop_cd_t    = ace_ccu_snoop_fanout_pkg::snoop_cd_t,
   parameter type snoop_req_t   = ace_ccu_snoop_fanout_pkg::snoop_req_t,
   parameter type snoop_resp_t  = ace_ccu_snoop_fanout_pkg::snoop_resp_t,
   parameter type domain_mask_t = logic [NoMstPorts-1:0]
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  snoop_req_t   slv_req_i,
   output snoop_resp_t  slv_resp_o,
   input  domain_mask_t slv_mask_i,
   output snoop_req_t   mst_reqs_o  [NoMstPorts],
   input  snoop_resp_t  mst_resps_i [NoMstPorts],
   output logic         busy_o
);
   localparam int unsigned CdBeats = DcacheLineWidth / AxiDataWidth;
   localparam int unsigned CntW    = $clog2(CdBeats) + 1;
   localparam int unsigned IdxW    = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;
   localparam logic [CntW-1:0] LastBeat = CntW'(CdBeats - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] AC_CR = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;
   localparam logic [1:0] DATA  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic                  ac_ready_q, ac_ready_d;
   snoop_ac_t             ac_q, ac_d;
   snoop_cr_t             resp_q, resp_d;
   logic [NoMstPorts-1:0] ac_pend_q, ac_pend_d, cr_pend_q, cr_pend_d, cd_pend_q, cd_pend_d;
   logic [IdxW-1:0]       src_q, src_d;
   logic [CntW-1:0]       cnt_q [NoMstPorts];
   logic [CntW-1:0]       cnt_d [NoMstPorts];

   snoop_cd_t src_cd;
   logic      src_valid, src_ready, drain_done, beat;
   logic      unused_cd_last;

   function automatic logic [IdxW-1:0] lowest_set(input logic [NoMstPorts-1:0] m);
      lowest_set = '0;
      for (int i = NoMstPorts - 1; i >= 0; i--) if (m[i]) lowest_set = IdxW'(i);
   endfunction

   // Downstream last is ignored: upstream last comes from the beat counter.
   always_comb begin
      src_cd      = mst_resps_i[src_q].cd;
      src_cd.last = (cnt_q[src_q] == LastBeat);
      src_valid   = (state_q == DATA) && cd_pend_q[src_q] && mst_resps_i[src_q].cd_valid;
      unused_cd_last = mst_resps_i[src_q].cd.last;
   end

`ifdef ACE_CCU_SNOOP_FANOUT_CD_SPILL_EN
   snoop_cd_t  spill_q [2];
   logic       wr_ptr_q, rd_ptr_q, push, pop;
   logic [1:0] fill_q, fill_d;

   assign src_ready  = (fill_q != 2'd2);
   assign push       = src_valid && src_ready;
   assign pop        = (fill_q != 2'd0) && slv_req_i.cd_ready;
   assign fill_d     = fill_q + {1'b0, push} - {1'b0, pop};
   assign drain_done = (fill_d == 2'd0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fill_q   <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         fill_q <= fill_d;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // NOTE: payload slots are left unreset on purpose; fill_q alone decides whether a slot is meaningful.
   always_ff @(posedge clk_i) begin
      if (push) spill_q[wr_ptr_q] <= src_cd;
   end
`else
   assign src_ready  = slv_req_i.cd_ready;
   assign drain_done = 1'b1;
`endif

   // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      ac_d      = ac_q;
      resp_d    = resp_q;
      ac_pend_d = ac_pend_q;
      cr_pend_d = cr_pend_q;
      cd_pend_d = cd_pend_q;
      src_d     = src_q;
      cnt_d     = cnt_q;
      beat      = 1'b0;
      slv_resp_o          = '0;
      slv_resp_o.ac_ready = ac_ready_q;
      for (int i = 0; i < NoMstPorts; i++) begin
         mst_reqs_o[i]    = '0;
         mst_reqs_o[i].ac = ac_q;
      end
      case (state_q)
         IDLE: begin
            if (slv_req_i.ac_valid && ac_ready_q) begin
               ac_d      = slv_req_i.ac;
               ac_pend_d = slv_mask_i;
               cr_pend_d = slv_mask_i;
               cd_pend_d = '0;
               resp_d    = '0;
               state_d   = (slv_mask_i == '0) ? RESP : AC_CR;
            end
         end
         AC_CR: begin
            for (int i = 0; i < NoMstPorts; i++) begin
               mst_reqs_o[i].ac_valid = ac_pend_q[i];
               mst_reqs_o[i].cr_ready = cr_pend_q[i];
               if (ac_pend_q[i] && mst_resps_i[i].ac_ready) ac_pend_d[i] = 1'b0;
               if (cr_pend_q[i] && mst_resps_i[i].cr_valid) begin
                  cr_pend_d[i] = 1'b0;
                  resp_d       = resp_d | mst_resps_i[i].cr_resp;
                  if (mst_resps_i[i].cr_resp[0]) cd_pend_d[i] = 1'b1;
               end
            end
            if (ac_pend_d == '0 && cr_pend_d == '0) state_d = RESP;
         end
         RESP: begin
            slv_resp_o.cr_valid = 1'b1;
            slv_resp_o.cr_resp  = resp_q;
            if (slv_req_i.cr_ready) begin
               if (cd_pend_q != '0) begin
                  state_d = DATA;
                  src_d   = lowest_set(cd_pend_q);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            for (int i = 0; i < NoMstPorts; i++) begin
               if (cd_pend_q[i]) begin
                  if (IdxW'(i) == src_q) begin
                     mst_reqs_o[i].cd_ready = src_ready;
                     beat = src_valid && src_ready;
                  end else begin
                     mst_reqs_o[i].cd_ready = 1'b1;
                     beat = mst_resps_i[i].cd_valid;
                  end
                  if (beat) begin
                     if (cnt_q[i] == LastBeat) begin
                        cnt_d[i]     = '0;
                        cd_pend_d[i] = 1'b0;
                     end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                     end
                  end
               end
            end
            if (cd_pend_d == '0 && drain_done) state_d = IDLE;
         end
      endcase
`ifdef ACE_CCU_SNOOP_FANOUT_CD_SPILL_EN
      slv_resp_o.cd_valid = (fill_q != 2'd0);
      slv_resp_o.cd       = spill_q[rd_ptr_q];
`else
      if (state_q == DATA) begin
         slv_resp_o.cd_valid = src_valid;
         slv_resp_o.cd       = src_cd;
      end
`endif
      ac_ready_d = (state_d == IDLE);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         ac_ready_q <= 1'b0;
         ac_q       <= '0;
         resp_q     <= '0;
         ac_pend_q  <= '0;
         cr_pend_q  <= '0;
         cd_pend_q  <= '0;
         src_q      <= '0;
         for (int i = 0; i < NoMstPorts; i++) cnt_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         ac_ready_q <= ac_ready_d;
         ac_q       <= ac_d;
         resp_q     <= resp_d;
         ac_pend_q  <= ac_pend_d;
         cr_pend_q  <= cr_pend_d;
         cd_pend_q  <= cd_pend_d;
         src_q      <= src_d;
         cnt_q      <= cnt_d;
      end
   end

   assign busy_o = (state_q != IDLE);
endmodule

// File: tb/tb_ace_ccu_snoop_fanout.sv
// Directed bench for ace_ccu_snoop_fanout: models four snoop ports and the upstream controller cycle by cycle.
module tb_ace_ccu_snoop_fanout;
   import ace_ccu_snoop_fanout_pkg::*;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   snoop_req_t  slv_req;
   snoop_resp_t slv_resp;
   logic [N-1:0] slv_mask;
   snoop_req_t  mst_reqs  [N];
   snoop_resp_t mst_resps [N];
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ace_ccu_snoop_fanout #(.NoMstPorts(N)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .slv_req_i(slv_req), .slv_resp_o(slv_resp), .slv_mask_i(slv_mask),
      .mst_reqs_o(mst_reqs), .mst_resps_i(mst_resps), .busy_o(busy)
   );

   // Port and upstream model state
   int        cyc, cr_hold;
   logic      ac_want, cd_toggle;
   logic [4:0] cr_val [N];
   logic      cr_same [N], p_has_ac [N], p_cr_done [N], p_cd_act [N];
   int        p_ac_dly [N], p_cd_beat [N], ac_cyc [N], cr_cyc [N];
   int        ac_hs_cyc, first_acv, n_acv, last_cr_cyc, crv_cyc, cr_up_hs_cyc, n_cr, n_up, stab_err, arb_err;
   logic [4:0] got_cr, cr_prev;
   logic      cr_prev_stall, cd_prev_stall;
   snoop_cd_t cd_prev;
   logic [127:0] up_data [8];
   logic      up_last [8];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] pat(input int p, input int b);
      return {64'hA5A5_5A5A_0F0F_F0F0, 32'(p), 32'(b)};
   endfunction

   task automatic idle_inputs();
      slv_req  = '0;
      slv_mask = '0;
      for (int i = 0; i < N; i++) mst_resps[i] = '0;
   endtask

   task automatic init_txn();
      ac_want = 1'b0; cr_hold = 0; cd_toggle = 1'b0;
      for (int i = 0; i < N; i++) begin
         cr_val[i] = '0; cr_same[i] = 1'b0; p_has_ac[i] = 1'b0; p_cr_done[i] = 1'b0;
         p_cd_act[i] = 1'b0; p_ac_dly[i] = 0; p_cd_beat[i] = 0; ac_cyc[i] = -1; cr_cyc[i] = -1;
      end
      ac_hs_cyc = -1; first_acv = -1; n_acv = 0; last_cr_cyc = -1; crv_cyc = -1; cr_up_hs_cyc = -1;
      n_cr = 0; n_up = 0; stab_err = 0; arb_err = 0; got_cr = '1; cr_prev = '0;
      cr_prev_stall = 1'b0; cd_prev_stall = 1'b0; cd_prev = '0;
      for (int b = 0; b < 8; b++) begin up_data[b] = '0; up_last[b] = 1'b0; end
   endtask

   // One clock: drive at negedge, settle, then record the handshakes the next posedge will complete.
   task automatic tick();
      @(negedge clk);
      cyc++;
      slv_req.ac_valid = ac_want;
      slv_req.ac       = '{addr: 44'h123_4567_89A0, snoop: 4'h7, prot: 3'h2};
      slv_req.cr_ready = (cr_hold == 0);
      slv_req.cd_ready = cd_toggle ? ~slv_req.cd_ready : 1'b1;
      for (int i = 0; i < N; i++) begin
         mst_resps[i].ac_ready = (p_ac_dly[i] == 0);
         mst_resps[i].cr_resp  = cr_val[i];
         mst_resps[i].cd_valid = p_cd_act[i];
         mst_resps[i].cd.data  = pat(i, p_cd_beat[i]);
         mst_resps[i].cd.last  = 1'b1;
      end
      #1;
      for (int i = 0; i < N; i++)
         mst_resps[i].cr_valid = !p_cr_done[i] && (p_has_ac[i] ||
                                 (cr_same[i] && mst_reqs[i].ac_valid && mst_resps[i].ac_ready));
      #1;
      if (slv_req.ac_valid && slv_resp.ac_ready) begin ac_hs_cyc = cyc; ac_want = 1'b0; end
      if (busy && slv_resp.ac_ready) arb_err++;
      for (int i = 0; i < N; i++) begin
         if (mst_reqs[i].ac_valid) begin
            n_acv++;
            if (first_acv < 0) first_acv = cyc;
            if (mst_resps[i].ac_ready) begin p_has_ac[i] = 1'b1; ac_cyc[i] = cyc; end
            else if (p_ac_dly[i] > 0) p_ac_dly[i]--;
         end
         if (mst_resps[i].cr_valid && mst_reqs[i].cr_ready) begin
            p_cr_done[i] = 1'b1; cr_cyc[i] = cyc; last_cr_cyc = cyc;
            if (cr_val[i][0]) p_cd_act[i] = 1'b1;
         end
         if (mst_resps[i].cd_valid && mst_reqs[i].cd_ready) begin
            p_cd_beat[i]++;
            if (p_cd_beat[i] == 4) p_cd_act[i] = 1'b0;
         end
      end
      if (cr_prev_stall && (!slv_resp.cr_valid || slv_resp.cr_resp !== cr_prev)) stab_err++;
      cr_prev_stall = slv_resp.cr_valid && !slv_req.cr_ready;
      cr_prev       = slv_resp.cr_resp;
      if (slv_resp.cr_valid) begin
         if (crv_cyc < 0) crv_cyc = cyc;
         if (slv_req.cr_ready) begin n_cr++; got_cr = slv_resp.cr_resp; cr_up_hs_cyc = cyc; end
         else if (cr_hold > 0) cr_hold--;
      end
      if (cd_prev_stall && (!slv_resp.cd_valid || slv_resp.cd !== cd_prev)) stab_err++;
      cd_prev_stall = slv_resp.cd_valid && !slv_req.cd_ready;
      cd_prev       = slv_resp.cd;
      if (slv_resp.cd_valid && slv_req.cd_ready) begin
         if (n_up < 8) begin up_data[n_up] = slv_resp.cd.data; up_last[n_up] = slv_resp.cd.last; end
         n_up++;
      end
   endtask

   task automatic run_txn(input logic [N-1:0] mask, input int abort_beat, output logic ok);
      slv_mask = mask;
      ac_want  = 1'b1;
      ok       = 1'b0;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (abort_beat >= 0 && n_up == abort_beat) begin ok = 1'b1; break; end
         if (ac_hs_cyc >= 0 && cyc > ac_hs_cyc && !busy) begin ok = 1'b1; break; end
      end
   endtask

   task automatic check_data(input string pfx, input int src);
      check({pfx, "_beats"}, 128'(n_up), 128'(4));
      for (int b = 0; b < 4; b++) begin
         check($sformatf("%s_data%0d", pfx, b), up_data[b], pat(src, b));
         check($sformatf("%s_last%0d", pfx, b), 128'(up_last[b]), 128'(b == 3));
      end
   endtask

   task automatic scen_basic(input string pfx);
      logic ok;
      init_txn();
      cr_val[0] = 5'b00000; cr_val[2] = 5'b01001;
      run_txn(4'b0101, -1, ok);
      check({pfx, "_done"}, 128'(ok), 128'(1));
      check({pfx, "_cr"}, 128'(got_cr), 128'(5'b01001));
      check({pfx, "_acv_lat"}, 128'(first_acv), 128'(ac_hs_cyc + 1));
      check({pfx, "_cr_lat"}, 128'(crv_cyc), 128'(last_cr_cyc + 1));
      check_data(pfx, 2);
      check({pfx, "_arb"}, 128'(arb_err), 128'(0));
   endtask

   initial begin
      logic ok;
      cyc = 0;
      idle_inputs();
      init_txn();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ac_ready", 128'(slv_resp.ac_ready), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_mst_ac_valid", 128'(mst_reqs[0].ac_valid | mst_reqs[3].ac_valid), 128'(0));
      @(negedge clk); rst_n = 1'b1; #1;
      check("rel_ac_ready_low", 128'(slv_resp.ac_ready), 128'(0));
      @(posedge clk); #1;
      check("rel_ac_ready_high", 128'(slv_resp.ac_ready), 128'(1));

      scen_basic("t1");

      init_txn();
      cr_val[0] = 5'b00000; cr_val[1] = 5'b00001; cr_val[2] = 5'b00100; cr_val[3] = 5'b10001;
      run_txn(4'b1111, -1, ok);
      check("t2_done", 128'(ok), 128'(1));
      check("t2_cr", 128'(got_cr), 128'(5'b10101));
      check_data("t2", 1);
      check("t2_src_beats", 128'(p_cd_beat[1]), 128'(4));
      check("t2_drain_beats", 128'(p_cd_beat[3]), 128'(4));

      init_txn();
      run_txn(4'b0000, -1, ok);
      check("t3_done", 128'(ok), 128'(1));
      check("t3_cr", 128'(got_cr), 128'(0));
      check("t3_cr_lat", 128'(crv_cyc), 128'(ac_hs_cyc + 1));
      check("t3_no_ac", 128'(n_acv), 128'(0));
      check("t3_no_cd", 128'(n_up), 128'(0));
      check("t3_one_cr", 128'(n_cr), 128'(1));

      init_txn();
      cr_val[0] = 5'b00010; cr_val[3] = 5'b01000; cr_same[0] = 1'b1; p_ac_dly[3] = 10;
      run_txn(4'b1001, -1, ok);
      check("t4_done", 128'(ok), 128'(1));
      check("t4_cr", 128'(got_cr), 128'(5'b01010));
      check("t4_p0_same", 128'(cr_cyc[0]), 128'(ac_cyc[0]));
      check("t4_p3_ac", 128'(ac_cyc[3]), 128'(ac_hs_cyc + 11));
      check("t4_cr_lat", 128'(crv_cyc), 128'(cr_cyc[3] + 1));
      check("t4_arb", 128'(arb_err), 128'(0));
      check("t4_no_cd", 128'(n_up), 128'(0));

      init_txn();
      cr_val[0] = 5'b00001; cr_hold = 5; cd_toggle = 1'b1;
      run_txn(4'b0001, -1, ok);
      check("t5_done", 128'(ok), 128'(1));
      check("t5_cr", 128'(got_cr), 128'(5'b00001));
      check("t5_cr_stall", 128'(cr_up_hs_cyc), 128'(crv_cyc + 5));
      check("t5_stable", 128'(stab_err), 128'(0));
      check_data("t5", 0);

      init_txn();
      cr_val[0] = 5'b00001;
      run_txn(4'b0001, 2, ok);
      check("t6_reach_beat2", 128'(ok), 128'(1));
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      check("t6_cd_valid", 128'(slv_resp.cd_valid), 128'(0));
      check("t6_cr_valid", 128'(slv_resp.cr_valid), 128'(0));
      check("t6_ac_ready", 128'(slv_resp.ac_ready), 128'(0));
      check("t6_busy", 128'(busy), 128'(0));
      check("t6_mst_cd_ready", 128'(mst_reqs[0].cd_ready), 128'(0));
      idle_inputs();
      init_txn();
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1; #1;
      check("t6_rel_ac_ready_low", 128'(slv_resp.ac_ready), 128'(0));
      @(posedge clk); #1;
      check("t6_rel_ac_ready_high", 128'(slv_resp.ac_ready), 128'(1));
      scen_basic("t6_fresh");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ace_ccu_snoop_fanout.md
# ace_ccu_snoop_fanout

Broadcasts one upstream ACE snoop transaction (AC) to a masked subset of `NoMstPorts` cache snoop ports, collects every CR response, and merges them into a single upstream CR. CD data comes from exactly one responder; the block drains and discards CD from all other responders. It sits between the CCU snoop controllers (one per read/write path) and the per-master snoop interfaces. It is the N-port successor of the fixed two-path snoop routing, with one transaction in flight.

## Interface
- `NoMstPorts`, 4: number of downstream snoop ports (≥1).
- `DcacheLineWidth`, 512: cache line bits.
- `AxiDataWidth`, 128: CD data bits. `CdBeats = DcacheLineWidth/AxiDataWidth`, must be ≥1.
- `snoop_ac_t` / `snoop_cr_t` / `snoop_cd_t`, logic: snoop channel types.
- `snoop_req_t` / `snoop_resp_t`, logic: snoop port request/response types (ac, ac_valid, cr_ready, cd_ready / ac_ready, cr_valid, cr_resp, cd_valid, cd).
- `domain_mask_t`, logic: `NoMstPorts`-bit target mask.
- Clock and reset: one clock; reset is asynchronous and active-low (`clk_i`, `rst_ni`).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  async active-low reset.
- `slv_req_i`  in  snoop_req_t  upstream AC and CR/CD readies.
- `slv_resp_o`  out  snoop_resp_t  upstream ac_ready, merged CR, forwarded CD.
- `slv_mask_i`  in  domain_mask_t  target ports; sampled with AC handshake.
- `mst_reqs_o`  out  snoop_req_t[NoMstPorts]  downstream AC, cr_ready, cd_ready.
- `mst_resps_i`  in  snoop_resp_t[NoMstPorts]  downstream CR/CD.
- `busy_o`  out  1  high in any state other than IDLE.

## Operation
- FSM: IDLE → AC_CR → RESP → DATA → IDLE. RESP → IDLE when merged DataTransfer = 0.
- IDLE: `ac_ready` = 1. On the AC handshake, register ac and mask into `ac_pend` and `cr_pend`, then go to AC_CR. If the mask is all zero, go to RESP with a merged CR of 0.
- AC_CR: drive `ac_valid[i]` = `ac_pend[i]`; clear bit i on `ac_ready[i]`. Drive `cr_ready[i]` = `cr_pend[i]`; clear bit i on the CR handshake. A port may return CR in the same cycle as its AC handshake or later.
  - Accumulate per-bit OR over crresp[4:0] = {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
  - Set `cd_pend[i]` when DataTransfer[i] = 1.
  - Data source = lowest index with DataTransfer = 1.
  - Leave the state when `ac_pend` and `cr_pend` are both zero.
- RESP: upstream `cr_valid` = 1 with the merged resp. Hold it stable until `cr_ready`. Then go to DATA if `cd_pend` ≠ 0, else IDLE.
- DATA:
  - Forward the source port's CD upstream, data unchanged.
  - Drive upstream `last` from a beat counter at beat `CdBeats`-1; ignore downstream `last`.
  - For non-source ports with `cd_pend` set, hold `cd_ready` = 1 and discard their data, each with its own beat counter.
  - Clear `cd_pend[i]` after `CdBeats` beats. Go to IDLE when `cd_pend` = 0.
- Counters: `$clog2(CdBeats)`+1 bits per port, wrap to 0 on completion.

## Timing
- Reset values: every valid/ready output 0, `busy_o` 0, all pend masks 0. Upstream `ac_ready` is registered and rises the first cycle after reset release.
- AC accepted at cycle t → downstream `ac_valid` at t+1. `ac_ready` is 0 from t+1.
- Last CR handshake at t → merged `cr_valid` at t+1.
- CD passthrough is combinational: source `cd_valid` → upstream `cd_valid` same cycle, and upstream `cd_ready` → source `cd_ready` same cycle.
- Simultaneous AC and CR handshakes on one port are both recorded.
- Reset asserted mid-transaction: immediate return to IDLE, all state cleared. No partial CR or CD is produced.
- Back-to-back: a new AC is accepted no earlier than the cycle after returning to IDLE.

## Configuration
- `ACE_CCU_SNOOP_FANOUT_CD_SPILL_EN` defined: the CD path goes through a 2-entry spill register.
  - +1 cycle CD latency.
  - No combinational ready/valid path from upstream to downstream.
  - DATA exits only after the spill register has also drained.
- Not defined: combinational CD passthrough as above.

## Test plan
- Mask 4'b0101, port0 CR 5'b00000, port2 CR 5'b01001 → merged CR 5'b01001. Four CD beats from port2 are forwarded, `last` on beat 3, then IDLE.
- Mask 4'b1111, ports 1 and 3 return DataTransfer → port1 data forwarded, port3 4 beats drained with no upstream beats. Transaction ends only after both complete.
- Mask 4'b0000 → merged CR 0 one cycle after the AC handshake, no downstream AC, no CD phase.
- Port3 delays `ac_ready` 10 cycles, port0 returns CR in its AC-handshake cycle → merged CR only after port3's CR; upstream `ac_ready` stays low throughout.
- Upstream `cr_ready` held low 5 cycles and `cd_ready` toggled every cycle → CR and CD payloads are stable while stalled, with exactly `CdBeats` upstream beats.
- `rst_ni` pulsed low during DATA beat 2 → all outputs 0. `ac_ready` = 1 the cycle after release, and a fresh transaction completes correctly.
